// File: rtl/puzzle_setup_key_in.sv
// puzzle_setup_key_in: Avalon-MM input PIO for the puzzle_setup board keys.
// Each input bit is synchronised and then (optionally) debounced. Presses are
// latched in EDGECAPTURE, and a maskable level interrupt is raised from it.
// Optional feature macro: PUZZLE_KEY_DEBOUNCE_EN. When it is defined, the
// per-bit debounce filter is built; otherwise stable follows sync2 directly.
module puzzle_setup_key_in #(
    parameter int WIDTH           = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [31:0]       writedata,
    input  logic [WIDTH-1:0]  in_port,
    output logic [31:0]       readdata,
    output logic              irq
);

    localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_LEVEL}};

    // Catch illegal configurations at elaboration time.
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("puzzle_setup_key_in: WIDTH must be 1..32");
    end
    if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
        $error("puzzle_setup_key_in: DEBOUNCE_CYCLES must be >= 1");
    end

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [WIDTH-1:0] stable;
    logic [WIDTH-1:0] update;
    logic [WIDTH-1:0] pe;
    logic [WIDTH-1:0] irqmask;
    logic [WIDTH-1:0] edgecapture;
    logic             wr_en;

    assign wr_en = chipselect & ~write_n;

    // Two-flop synchroniser for the asynchronous board inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= IDLE_WORD;
            sync2 <= IDLE_WORD;
        end else begin
            sync1 <= in_port;
            sync2 <= sync1;
        end
    end

`ifdef PUZZLE_KEY_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt [WIDTH];

    // Accept a new level only after it has been seen DEBOUNCE_CYCLES times in a row.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= IDLE_WORD;
            for (int i = 0; i < WIDTH; i++) cnt[i] <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // A bit updates on the edge where its counter expires with a differing level.
    always_comb begin
        update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            update[i] = (sync2[i] != stable[i]) && (cnt[i] == CNT_LAST);
        end
    end
`else
    // Without the filter, stable simply tracks the synchronised inputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stable <= IDLE_WORD;
        end else begin
            stable <= sync2;
        end
    end

    assign update = sync2 ^ stable;
`endif

    // A press is an update toward the non-idle level; releases are ignored.
    assign pe = update & (sync2 ^ IDLE_WORD);

    // Interrupt mask register, loaded by writes to address 2.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask <= '0;
        end else if (wr_en && address == 2'd2) begin
            irqmask <= writedata[WIDTH-1:0];
        end
    end

    // Press capture with write-1-to-clear; a press on the clearing edge wins.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            edgecapture <= '0;
        end else if (wr_en && address == 2'd3) begin
            edgecapture <= (edgecapture & ~writedata[WIDTH-1:0]) | pe;
        end else begin
            edgecapture <= edgecapture | pe;
        end
    end

    assign irq = |(edgecapture & irqmask);

    // Zero-wait-state read mux, zero-extended to 32 bits.
    always_comb begin
        readdata = 32'd0;
        case (address)
            2'd0:    readdata[WIDTH-1:0] = stable;
            2'd2:    readdata[WIDTH-1:0] = irqmask;
            2'd3:    readdata[WIDTH-1:0] = edgecapture;
            default: readdata = 32'd0;
        endcase
    end

    // Upper write-data bits have no storage behind them.
    if (WIDTH < 32) begin : g_unused_wd
        logic unused_writedata;
        assign unused_writedata = |writedata[31:WIDTH];
    end

endmodule

// File: tb/tb_puzzle_setup_key_in.sv
// Directed testbench for puzzle_setup_key_in (WIDTH=10, DEBOUNCE_CYCLES=4).
// Expected timing adapts to whether PUZZLE_KEY_DEBOUNCE_EN is defined.
module tb_puzzle_setup_key_in;

    localparam int WIDTH = 10;
    localparam int DEB   = 4;
`ifdef PUZZLE_KEY_DEBOUNCE_EN
    localparam int EDGES = 2 + DEB;
`else
    localparam int EDGES = 3;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        address = 2'd0;
    logic              chipselect = 1'b0;
    logic              write_n = 1'b1;
    logic [31:0]       writedata = 32'd0;
    logic [WIDTH-1:0]  in_port = 10'h3FF;
    logic [31:0]       readdata;
    logic              irq;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] v;

    puzzle_setup_key_in #(
        .WIDTH(WIDTH),
        .DEBOUNCE_CYCLES(DEB),
        .IDLE_LEVEL(1'b1)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .address(address),
        .chipselect(chipselect),
        .write_n(write_n),
        .writedata(writedata),
        .in_port(in_port),
        .readdata(readdata),
        .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic test_reset;
        in_port = 10'h3FF;
        reset_n = 1'b0;
        tick(2);
        reset_n = 1'b1;
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL reset_data got %h want %h", v, 32'h3FF); end
        rd(2'd1, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_rsvd got %h want %h", v, 32'h0); end
        rd(2'd2, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_mask got %h want %h", v, 32'h0); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL reset_ec got %h want %h", v, 32'h0); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL reset_irq got %b want 0", irq); end
    endtask

`ifdef PUZZLE_KEY_DEBOUNCE_EN
    task automatic test_glitch;
        in_port[0] = 1'b0;
        tick(3);
        in_port[0] = 1'b1;
        tick(10);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL glitch_data got %h want %h", v, 32'h3FF); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL glitch_ec got %h want %h", v, 32'h0); end
    endtask
`else
    task automatic test_pulse;
        in_port[2] = 1'b0;
        tick(1);
        in_port[2] = 1'b1;
        tick(1);
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL pulse_early got %h want %h", v, 32'h0); end
        tick(1);
        rd(2'd3, v); tests_run++;
        if (v !== 32'h004) begin tests_failed++; $display("FAIL pulse_ec got %h want %h", v, 32'h004); end
        wr(2'd3, 32'h004);
        tick(3);
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL pulse_clr got %h want %h", v, 32'h0); end
    endtask
`endif

    task automatic test_press;
        in_port[0] = 1'b0;
        tick(EDGES - 1);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL press_early got %h want %h", v, 32'h3FF); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL press_early_ec got %h want %h", v, 32'h0); end
        tick(1);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FE) begin tests_failed++; $display("FAIL press_data got %h want %h", v, 32'h3FE); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h001) begin tests_failed++; $display("FAIL press_ec got %h want %h", v, 32'h001); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL press_irq_masked got %b want 0", irq); end
        in_port[0] = 1'b1;
        tick(EDGES + 2);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL release_data got %h want %h", v, 32'h3FF); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h001) begin tests_failed++; $display("FAIL release_ec got %h want %h", v, 32'h001); end
    endtask

    task automatic test_irq;
        wr(2'd2, 32'h001);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set got %b want 1", irq); end
        rd(2'd2, v); tests_run++;
        if (v !== 32'h001) begin tests_failed++; $display("FAIL mask_rb got %h want %h", v, 32'h001); end
        wr(2'd3, 32'h001);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_w1c got %b want 0", irq); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL ec_w1c got %h want %h", v, 32'h0); end
    endtask

    task automatic test_mask_clear;
        in_port[0] = 1'b0;
        tick(EDGES + 1);
        in_port[0] = 1'b1;
        tick(EDGES + 2);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_repress got %b want 1", irq); end
        wr(2'd2, 32'h000);
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_unmask got %b want 0", irq); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h001) begin tests_failed++; $display("FAIL ec_held got %h want %h", v, 32'h001); end
    endtask

    task automatic test_set_wins;
        in_port[3] = 1'b0;
        tick(EDGES - 1);
        wr(2'd3, 32'h009);
        rd(2'd3, v); tests_run++;
        if (v !== 32'h008) begin tests_failed++; $display("FAIL set_wins got %h want %h", v, 32'h008); end
        in_port[3] = 1'b1;
        tick(EDGES + 2);
        wr(2'd0, 32'h000);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL data_ro got %h want %h", v, 32'h3FF); end
        wr(2'd1, 32'hFFFF_FFFF);
        rd(2'd1, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL rsvd_ro got %h want %h", v, 32'h0); end
        wr(2'd3, 32'h3FF);
    endtask

    task automatic test_back_to_back;
        in_port = 10'h1DF;
        tick(EDGES);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h1DF) begin tests_failed++; $display("FAIL multi_data got %h want %h", v, 32'h1DF); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h220) begin tests_failed++; $display("FAIL multi_ec got %h want %h", v, 32'h220); end
        wr(2'd2, 32'h200);
        tests_run++;
        if (irq !== 1'b1) begin tests_failed++; $display("FAIL multi_irq got %b want 1", irq); end
        in_port = 10'h3FF;
        tick(EDGES + 2);
    endtask

    task automatic test_reset_mid;
        in_port[1] = 1'b0;
        tick(2);
        reset_n = 1'b0;
        tick(1);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL rmid_data got %h want %h", v, 32'h3FF); end
        rd(2'd2, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL rmid_mask got %h want %h", v, 32'h0); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h0) begin tests_failed++; $display("FAIL rmid_ec got %h want %h", v, 32'h0); end
        tests_run++;
        if (irq !== 1'b0) begin tests_failed++; $display("FAIL rmid_irq got %b want 0", irq); end
        reset_n = 1'b1;
        tick(EDGES - 1);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FF) begin tests_failed++; $display("FAIL rmid_restart got %h want %h", v, 32'h3FF); end
        tick(1);
        rd(2'd0, v); tests_run++;
        if (v !== 32'h3FD) begin tests_failed++; $display("FAIL rmid_accept got %h want %h", v, 32'h3FD); end
        rd(2'd3, v); tests_run++;
        if (v !== 32'h002) begin tests_failed++; $display("FAIL rmid_ec2 got %h want %h", v, 32'h002); end
    endtask

    initial begin
        test_reset;
`ifdef PUZZLE_KEY_DEBOUNCE_EN
        test_glitch;
`else
        test_pulse;
`endif
        test_press;
        test_irq;
        test_mask_clear;
        test_set_wins;
        test_back_to_back;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
